// File: rtl/cas_pkg.sv
// Shared types and default timing for the cassette playback stage.
package cas_pkg;

    // Playback sequencer states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH      = 3'd1,
        LATCH      = 3'd2,
        CLK_PULSE  = 3'd3,
        GAP1       = 3'd4,
        DATA_PULSE = 3'd5,
        GAP2       = 3'd6,
        END        = 3'd7
    } cas_state_t;

    // Model I 500-baud timing at the 1.774 MHz CPU tick rate
    localparam int unsigned CELL_TICKS_DEF  = 3548;
    localparam int unsigned PULSE_TICKS_DEF = 222;
    localparam int unsigned HALF_TICKS_DEF  = 1774;

    // Download address bit that selects the cassette region
    localparam int unsigned CAS_REGION_BIT = 16;

    // Tape length / position width: 0..65536 inclusive
    localparam int unsigned LEN_W = 17;

endpackage

// File: rtl/cas_player.sv
// Cassette playback: reads the downloaded CAS image and regenerates the
// Model I 500-baud clock/data pulse stream for the CPU cassette input.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for motor on, no download, and unread tape left
// FETCH      | read strobe issued for the byte at pos
// LATCH      | RAM data captured into the shift register, pos advances
// CLK_PULSE  | clock pulse high for PULSE_TICKS
// GAP1       | low until the cell reaches HALF_TICKS
// DATA_PULSE | current bit (MSB first) driven for PULSE_TICKS
// GAP2       | low until the cell reaches CELL_TICKS, then next bit/byte
// END        | tape exhausted; only rewind or a new download leaves
module cas_player
    import cas_pkg::*;
#(
    parameter int unsigned CELL_TICKS  = CELL_TICKS_DEF,
    parameter int unsigned PULSE_TICKS = PULSE_TICKS_DEF,
    parameter int unsigned HALF_TICKS  = HALF_TICKS_DEF
) (
    input  logic         clk42m,
    input  logic         reset,
    input  logic         ce_tick,
    input  logic         dn_go,
    input  logic         dn_wr,
    input  logic [16:0]  dn_addr,
    input  logic         motor,
    input  logic         rewind,
    output logic [15:0]  tape_addr,
    output logic         tape_rd,
    input  logic [7:0]   tape_data,
    output logic         cas_out,
    output logic         cas_active
);

    localparam int unsigned CW = $clog2(CELL_TICKS + 1);

    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_TICKS);
    localparam logic [CW-1:0] HALF_END  = CW'(HALF_TICKS);
    localparam logic [CW-1:0] DATA_END  = CW'(HALF_TICKS + PULSE_TICKS);
    localparam logic [CW-1:0] CELL_END  = CW'(CELL_TICKS);

    cas_state_t        state_q, state_d;
    logic              dn_go_q;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  pos_q, pos_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        byte_q;
    logic              rd_dly_q;
    logic [15:0]       tape_addr_q, tape_addr_d;
    logic              tape_rd_q, tape_rd_d;
    logic              cas_out_q, cas_out_d;
    logic              cas_active_q, cas_active_d;
    logic              dn_start;
    logic              more_tape;

    assign dn_start  = dn_go & ~dn_go_q;
    assign more_tape = (pos_q < len_q);
    assign cnt_inc   = cnt_q + 1'b1;

    // Tape length tracks the last cassette-region address written, +1
    always_comb begin
        len_d = len_q;
        if (dn_start) begin
            len_d = '0;
        end
        if (dn_go && dn_wr && dn_addr[CAS_REGION_BIT]) begin
            len_d = {1'b0, dn_addr[15:0]} + 17'd1;
        end
    end

    // Sequencer next state; download/rewind override, motor low freezes all
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        tape_addr_d = tape_addr_q;
        tape_rd_d   = 1'b0;

        if (dn_start || rewind) begin
            state_d = IDLE;
            pos_d   = '0;
        end else if (dn_go) begin
            state_d = IDLE;
        end else if (motor) begin
            case (state_q)
                IDLE: begin
                    if (more_tape) begin
                        state_d     = FETCH;
                        tape_rd_d   = 1'b1;
                        tape_addr_d = pos_q[15:0];
                    end
                end
                FETCH: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    // A motor stall in FETCH leaves the read data parked in byte_q
                    shreg_d   = rd_dly_q ? tape_data : byte_q;
                    bit_idx_d = 3'd7;
                    pos_d     = pos_q + 17'd1;
                    cnt_d     = '0;
                    state_d   = CLK_PULSE;
                end
                CLK_PULSE: begin
                    if (ce_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == PULSE_END) begin
                            state_d = GAP1;
                        end
                    end
                end
                GAP1: begin
                    if (ce_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == HALF_END) begin
                            state_d = DATA_PULSE;
                        end
                    end
                end
                DATA_PULSE: begin
                    if (ce_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DATA_END) begin
                            state_d = GAP2;
                        end
                    end
                end
                GAP2: begin
                    if (ce_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CELL_END) begin
                            if (bit_idx_q != 3'd0) begin
                                bit_idx_d = bit_idx_q - 3'd1;
                                shreg_d   = {shreg_q[6:0], 1'b0};
                                cnt_d     = '0;
                                state_d   = CLK_PULSE;
                            end else if (more_tape) begin
                                state_d     = FETCH;
                                tape_rd_d   = 1'b1;
                                tape_addr_d = pos_q[15:0];
                            end else begin
                                state_d = END;
                            end
                        end
                    end
                end
                END: begin
                    state_d = END;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the next state so they line up with it when registered
        cas_out_d    = motor & ((state_d == CLK_PULSE) |
                                ((state_d == DATA_PULSE) & shreg_d[7]));
        cas_active_d = (state_d != IDLE) && (state_d != END);
    end

    // Download edge detect and tape length
    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            dn_go_q <= 1'b0;
            len_q   <= '0;
        end else begin
            dn_go_q <= dn_go;
            len_q   <= len_d;
        end
    end

    // Sequencer state, position, cell counter and shift register
    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Park RAM read data on the cycle after the strobe
    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            rd_dly_q <= 1'b0;
            byte_q   <= '0;
        end else begin
            rd_dly_q <= tape_rd_q;
            if (rd_dly_q) begin
                byte_q <= tape_data;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk42m or posedge reset) begin
        if (reset) begin
            tape_addr_q  <= '0;
            tape_rd_q    <= 1'b0;
            cas_out_q    <= 1'b0;
            cas_active_q <= 1'b0;
        end else begin
            tape_addr_q  <= tape_addr_d;
            tape_rd_q    <= tape_rd_d;
            cas_out_q    <= cas_out_d;
            cas_active_q <= cas_active_d;
        end
    end

    assign tape_addr  = tape_addr_q;
    assign tape_rd    = tape_rd_q;
    assign cas_out    = cas_out_q;
    assign cas_active = cas_active_q;

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player: expected waveforms come from a per-cycle pulse model
// built from the cassette bit-cell rules, with motor holds and rewinds spliced in.
module tb_cas_player;

    localparam int CELL  = 16;
    localparam int HALF  = 8;
    localparam int PULSE = 2;

    logic        clk42m = 1'b0;
    logic        reset  = 1'b1;
    logic        ce_tick = 1'b1;
    logic        dn_go  = 1'b0;
    logic        dn_wr  = 1'b0;
    logic [16:0] dn_addr = '0;
    logic        motor  = 1'b0;
    logic        rewind = 1'b0;
    logic [15:0] tape_addr;
    logic        tape_rd;
    logic [7:0]  tape_data = '0;
    logic        cas_out;
    logic        cas_active;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int errors = 0;

    bit          exp_out[$];
    bit          exp_act[$];
    bit          exp_rd[$];
    int          exp_adr[$];
    bit          drv_mot[$];
    bit          drv_rew[$];
    logic [16:0] dl_addr[$];
    logic [7:0]  dl_data[$];

    cas_player #(.CELL_TICKS(CELL), .PULSE_TICKS(PULSE), .HALF_TICKS(HALF)) dut (
        .clk42m     (clk42m),
        .reset      (reset),
        .ce_tick    (ce_tick),
        .dn_go      (dn_go),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .motor      (motor),
        .rewind     (rewind),
        .tape_addr  (tape_addr),
        .tape_rd    (tape_rd),
        .tape_data  (tape_data),
        .cas_out    (cas_out),
        .cas_active (cas_active)
    );

    always #5 clk42m = ~clk42m;

    // Cassette RAM: data valid the cycle after the read strobe
    always @(posedge clk42m) begin
        if (tape_rd) tape_data <= mem[tape_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_s(input bit o, input bit a, input bit r, input int ad, input bit m, input bit rw);
        exp_out.push_back(o);
        exp_act.push_back(a);
        exp_rd.push_back(r);
        exp_adr.push_back(ad);
        drv_mot.push_back(m);
        drv_rew.push_back(rw);
    endtask

    // One byte on tape: two fetch cycles, then eight cells MSB first
    task automatic model_byte(input logic [7:0] b, input int adr);
        push_s(1'b0, 1'b1, 1'b1, adr, 1'b1, 1'b0);
        push_s(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        for (int bi = 7; bi >= 0; bi--) begin
            for (int k = 0; k < CELL; k++) begin
                push_s((k < PULSE) || (b[bi] && k >= HALF && k < HALF + PULSE),
                       1'b1, 1'b0, 0, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) push_s(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic model_cut(input int k);
        while (exp_out.size() > k) begin
            void'(exp_out.pop_back());
            void'(exp_act.pop_back());
            void'(exp_rd.pop_back());
            void'(exp_adr.pop_back());
            void'(drv_mot.pop_back());
            void'(drv_rew.pop_back());
        end
    endtask

    // Motor off for n cycles before sample k: output low, byte still active
    task automatic model_hold(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            exp_out.insert(k, 1'b0);
            exp_act.insert(k, 1'b1);
            exp_rd.insert(k, 1'b0);
            exp_adr.insert(k, 0);
            drv_mot.insert(k, 1'b0);
            drv_rew.insert(k, 1'b0);
        end
    endtask

    task automatic run_wave(input string name);
        for (int j = 0; j < exp_out.size(); j++) begin
            motor  = drv_mot[j];
            rewind = drv_rew[j];
            @(negedge clk42m);
            rewind = 1'b0;
            chk($sformatf("%s cas_out@%0d", name, j), cas_out, exp_out[j]);
            chk($sformatf("%s cas_active@%0d", name, j), cas_active, exp_act[j]);
            chk($sformatf("%s tape_rd@%0d", name, j), tape_rd, exp_rd[j]);
            if (exp_rd[j]) chk($sformatf("%s tape_addr@%0d", name, j), tape_addr, exp_adr[j]);
        end
        model_cut(0);
    endtask

    task automatic dl_push(input logic [16:0] a, input logic [7:0] d);
        dl_addr.push_back(a);
        dl_data.push_back(d);
    endtask

    // Download sequence; playback must stay silent and never read RAM
    task automatic download();
        dn_go = 1'b1;
        dn_wr = 1'b0;
        @(negedge clk42m);
        chk("dl start tape_rd", tape_rd, 0);
        chk("dl start cas_out", cas_out, 0);
        for (int i = 0; i < dl_addr.size(); i++) begin
            dn_wr   = 1'b1;
            dn_addr = dl_addr[i];
            if (dl_addr[i][16]) mem[dl_addr[i][15:0]] = dl_data[i];
            @(negedge clk42m);
            chk($sformatf("dl tape_rd@%0d", i), tape_rd, 0);
            chk($sformatf("dl cas_active@%0d", i), cas_active, 0);
        end
        dn_wr = 1'b0;
        dn_go = 1'b0;
        dl_addr.delete();
        dl_data.delete();
    endtask

    initial begin
        logic [7:0] r [3];
        logic [7:0] n [5];
        logic [7:0] b;
        int rises[$];
        int rds[$];
        bit prev;

        // Reset state, and no playback with an empty tape
        repeat (2) @(negedge clk42m);
        reset = 1'b0;
        chk("rst cas_out", cas_out, 0);
        chk("rst cas_active", cas_active, 0);
        chk("rst tape_rd", tape_rd, 0);
        chk("rst tape_addr", tape_addr, 0);
        model_idle(10);
        run_wave("empty");
        motor = 1'b0;

        // Directed two-byte tape
        dl_push(17'h10000, 8'hA5);
        dl_push(17'h10001, 8'h00);
        download();
        model_byte(8'hA5, 0);
        model_byte(8'h00, 1);
        model_idle(20);
        run_wave("a5_00");
        motor = 1'b0;

        // Motor dropped at tick 5 of bit 3 for 100 cycles
        for (int i = 0; i < 3; i++) begin
            r[i] = 8'($urandom_range(0, 255));
            dl_push(17'h10000 + 17'(i), r[i]);
        end
        download();
        for (int i = 0; i < 3; i++) model_byte(r[i], i);
        model_idle(20);
        model_hold(2 + (7 - 3) * CELL + 5, 100);
        run_wave("hold");

        // Rewind in the middle of the second byte
        for (int i = 0; i < 3; i++) begin
            r[i] = 8'($urandom_range(0, 255));
            dl_push(17'h10000 + 17'(i), r[i]);
        end
        download();
        for (int i = 0; i < 3; i++) model_byte(r[i], i);
        model_cut((2 + 8 * CELL) + 2 + 4 * CELL + 3);
        push_s(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) model_byte(r[i], i);
        model_idle(20);
        run_wave("rewind");

        // New download while playing: length is last cassette write + 1
        for (int i = 0; i < 3; i++) begin
            r[i] = 8'($urandom_range(0, 255));
            dl_push(17'h10000 + 17'(i), r[i]);
        end
        download();
        for (int i = 0; i < 3; i++) model_byte(r[i], i);
        model_cut((2 + 8 * CELL) + 2 + 2 * CELL + 9);
        run_wave("pre_dl");
        for (int i = 0; i < 5; i++) n[i] = 8'($urandom_range(0, 255));
        dl_push(17'h10000, n[0]);
        dl_push(17'h10001, n[1]);
        dl_push(17'h10002, n[2]);
        dl_push(17'h10003, n[3]);
        dl_push(17'h00007, 8'h5A);
        dl_push(17'h10001, n[4]);
        download();
        model_byte(n[0], 0);
        model_byte(n[4], 1);
        model_idle(20);
        run_wave("redl");
        motor = 1'b0;

        // Asynchronous reset during a data pulse
        b = 8'($urandom_range(0, 255)) | 8'h80;
        dl_push(17'h10000, b);
        download();
        model_byte(b, 0);
        model_cut(2 + HALF + 1);
        run_wave("pre_rst");
        #1 reset = 1'b1;
        #1;
        chk("async cas_out", cas_out, 0);
        chk("async cas_active", cas_active, 0);
        chk("async tape_addr", tape_addr, 0);
        @(negedge clk42m);
        reset = 1'b0;
        model_idle(30);
        run_wave("post_rst");
        motor = 1'b0;

        // ce_tick every third cycle; two blank bytes give clock pulses only
        dl_push(17'h10000, 8'h00);
        dl_push(17'h10001, 8'h00);
        download();
        prev = 1'b0;
        for (int j = 0; j < 1200 && rises.size() < 16; j++) begin
            ce_tick = (j % 3 == 0);
            motor   = 1'b1;
            @(negedge clk42m);
            if (tape_rd) rds.push_back(j);
            if (cas_out && !prev) rises.push_back(j);
            prev = cas_out;
        end
        ce_tick = 1'b1;
        chk("ce clock pulses", rises.size(), 16);
        if (rises.size() == 16 && rds.size() >= 2) begin
            for (int i = 1; i < 7; i++) begin
                chk($sformatf("ce cell b0 bit%0d", i), rises[i + 1] - rises[i], 3 * CELL);
                chk($sformatf("ce cell b1 bit%0d", i), rises[i + 9] - rises[i + 8], 3 * CELL);
            end
            chk("ce byte boundary", rises[8] - rises[7], 3 * CELL + 2);
            chk("ce fetch b0", rises[0] - rds[0], 2);
            chk("ce fetch b1", rises[8] - rds[1], 2);
            chk("ce rd addr", tape_addr, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback stage for the TRS-80 core. Consumes the CAS image written into the cassette region of the download space (download addresses 0x10000–0x1FFFF), fetches bytes from the cassette RAM, and regenerates the Model I 500-baud pulse stream presented to the CPU's cassette input port. It sits between the download/RAM path and the cassette-in bit of the I/O decode, gated by the CPU-controlled cassette motor relay.

## Interface
Parameters:
- CELL_TICKS, 3548, tick count per bit cell (2 ms at 1.774 MHz).
- PULSE_TICKS, 222, width of each clock or data pulse in ticks (about 125 µs).
- HALF_TICKS, 1774, tick offset from cell start to the data pulse.

Ports:
- clk42m, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- ce_tick, in, 1, CPU-rate clock enable; scales with the overclock setting so the ROM timing loops stay matched.
- dn_go, in, 1, download in progress.
- dn_wr, in, 1, download byte strobe.
- dn_addr, in, 17, download address; bit 16 set means cassette region.
- motor, in, 1, cassette motor relay from CPU port 0xFF.
- rewind, in, 1, single-cycle request to return to tape position 0.
- tape_addr, out, 16, cassette RAM read address.
- tape_rd, out, 1, single-cycle read strobe.
- tape_data, in, 8, RAM data, valid on the cycle after tape_rd.
- cas_out, out, 1, cassette input level to the CPU (1 = pulse).
- cas_active, out, 1, high while a byte is being played.

## Operation
- Tape length register `len`, 17 bits:
  - Cleared on the rising edge of dn_go.
  - On every `dn_go & dn_wr & dn_addr[16]`, set to dn_addr[15:0]+1.
  - Maximum value is 65536.
- Position register `pos`, 17 bits:
  - Set to 0 on reset, on rewind, and on the rising edge of dn_go.
  - Any of these also forces the FSM to IDLE.
- FSM states:
  - IDLE → FETCH when motor=1, dn_go=0, and pos<len.
  - FETCH: assert tape_rd with tape_addr=pos[15:0]; go to LATCH.
  - LATCH: capture tape_data into the shift register; bit index=7; pos increments; go to CLK_PULSE.
  - CLK_PULSE: cas_out=1 for PULSE_TICKS ticks.
  - GAP1: cas_out=0 until the cell tick counter reaches HALF_TICKS.
  - DATA_PULSE: cas_out equals the current bit for PULSE_TICKS ticks.
  - GAP2: cas_out=0 until the counter reaches CELL_TICKS. The next state is chosen as follows:
    - If bit index > 0: decrement the index, shift the register, go to CLK_PULSE.
    - Otherwise, if pos<len and motor=1: go to FETCH.
    - Otherwise: go to END.
  - END: cas_out=0, cas_active=0. Leaves on rewind or a new download only.
- Bit order is MSB first. The cell tick counter clears at each CLK_PULSE entry.
- Motor low mid-byte:
  - All counters and the state are frozen (tick counting stops).
  - cas_out is forced to 0.
  - When the motor returns, playback resumes exactly where it stopped.
- During dn_go, playback is held in IDLE and tape_rd is never asserted, so there is no RAM contention with download writes.
- len=0: the FSM stays in IDLE.
- pos reaching 65536: END, with no address wrap.
- Same-cycle priority: reset > download start > rewind > motor gating > normal advance.

## Timing
- Reset values:
  - cas_out=0, cas_active=0, tape_rd=0, tape_addr=0.
  - pos=0, len=0, state IDLE.
- All outputs are registered.
- From motor rising, with pos<len, to the first cas_out high: 3 clk42m cycles (IDLE, FETCH, LATCH), then the first CLK_PULSE.
- Tick counters advance only on cycles where ce_tick=1 and motor=1.
- Per bit: exactly CELL_TICKS ticks. Per byte: 8×CELL_TICKS ticks, plus 2 non-tick cycles for the fetch.
- The data pulse starts HALF_TICKS ticks after the clock pulse starts.
- cas_active is high from FETCH through the end of GAP2 of the last bit.

## Structure
- Shared package `cas_pkg`:
  - State enum `cas_state_t` (IDLE, FETCH, LATCH, CLK_PULSE, GAP1, DATA_PULSE, GAP2, END).
  - Default timing constants.
  - Cassette-region address bit index (16).
- Single module. A tick counter sub-module is not warranted.

## Test plan
Bench parameters for all scenarios: CELL_TICKS=16, HALF_TICKS=8, PULSE_TICKS=2, ce_tick=1.
- Download 2 bytes (0xA5, 0x00) at 0x10000/0x10001, then motor=1:
  - Expect tape_rd at addresses 0 then 1.
  - cas_out pulse pattern for 0xA5: clock pulse every 16 cycles, data pulses at bits 7, 5, 2, 0.
  - 0x00 produces clock pulses only.
  - Then END with cas_active=0.
- Motor dropped at tick 5 of bit 3, held 100 cycles, restored:
  - cas_out=0 during the hold.
  - The remaining waveform equals the uninterrupted one, shifted by 100 cycles.
- rewind during byte 2 of 3:
  - Next tape_rd is at address 0.
  - Full replay matches the first pass.
- New download started mid-playback:
  - tape_rd stays low throughout dn_go.
  - len equals the new last address+1; pos=0.
- Asynchronous reset asserted mid DATA_PULSE:
  - cas_out=0 immediately, without waiting for a clock edge.
  - After release, state is IDLE and len=0, so no play occurs with motor=1.
- ce_tick every 3rd cycle:
  - Bit cell measures 48 clk42m cycles.
  - Fetch overhead stays at 2 cycles.
